// File: rtl/led_cfg_sequencer.sv
// Configuration owner and rst/en sequencer for led_driver: shadow registers, commit
// validation, reset-and-reload or frame-aligned brightness update, frame counting.
module led_cfg_sequencer #(
    parameter int N_ROWS_MAX     = 64,
    parameter int N_COLS_MAX     = 256,
    parameter int BITDEPTH_MAX   = 8,
    parameter int LSB_BLANK_MAX  = 200,
    parameter int CTRL_REG_WIDTH = 32,
    parameter int RST_CYCLES     = 4
) (
    input  logic                      clk_i,
    input  logic                      ctrl_rst_i,
    input  logic                      host_we_i,
    input  logic [2:0]                host_addr_i,
    input  logic [CTRL_REG_WIDTH-1:0] host_wdata_i,
    output logic [CTRL_REG_WIDTH-1:0] host_rdata_o,
    input  logic                      commit_req_i,
    input  logic                      enable_i,
    input  logic                      drv_buffer_i,
    output logic                      drv_rst_o,
    output logic                      drv_en_o,
    output logic [CTRL_REG_WIDTH-1:0] drv_n_rows_o,
    output logic [CTRL_REG_WIDTH-1:0] drv_n_cols_o,
    output logic [CTRL_REG_WIDTH-1:0] drv_bitdepth_o,
    output logic [CTRL_REG_WIDTH-1:0] drv_lsb_blank_o,
    output logic [CTRL_REG_WIDTH-1:0] drv_brightness_o,
    output logic                      busy_o,
    output logic [4:0]                cfg_err_o,
    output logic [15:0]               frame_cnt_o
);
    localparam int W   = CTRL_REG_WIDTH;
    localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_RUN, S_CHECK, S_WAITFRAME, S_HALT, S_RST, S_RELEASE
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     shadow_q  [5];
    logic [W-1:0]     pending_q [5];
    logic [W-1:0]     active_q  [5];
    logic [4:0]       cfg_err_q, err_v;
    logic [15:0]      frame_cnt_q;
    logic [RCW-1:0]   rst_cnt_q;
    logic [W-1:0]     rdata_q, rdata_d;
    logic             origin_run_q;
    logic             buf_q, buf_edge;
    logic             drv_rst_q, drv_rst_d, drv_en_q, drv_en_d, busy_q, busy_d;
    logic             same_cfg, bright_only;

    function automatic logic [W-1:0] reset_val(input int idx);
        case (idx)
            0:       return W'(N_ROWS_MAX);
            1:       return W'(N_COLS_MAX);
            2:       return W'(BITDEPTH_MAX);
            3:       return W'(LSB_BLANK_MAX);
            default: return '0;
        endcase
    endfunction

    assign buf_edge = drv_buffer_i ^ buf_q;

    always_comb begin
        err_v[0] = (shadow_q[0] == '0) || (shadow_q[0] > W'(N_ROWS_MAX));
        err_v[1] = (shadow_q[1] == '0) || (shadow_q[1] > W'(N_COLS_MAX));
        err_v[2] = (shadow_q[2] == '0) || (shadow_q[2] > W'(BITDEPTH_MAX));
        err_v[3] = (shadow_q[3] == '0) || (shadow_q[3] > W'(LSB_BLANK_MAX));
        err_v[4] = !(shadow_q[4] < shadow_q[3]);
        bright_only = (shadow_q[0] == active_q[0]) && (shadow_q[1] == active_q[1]) &&
                      (shadow_q[2] == active_q[2]) && (shadow_q[3] == active_q[3]);
        same_cfg    = bright_only && (shadow_q[4] == active_q[4]);
    end

    always_ff @(posedge clk_i) begin
        if (ctrl_rst_i) begin
            state_q   <= S_IDLE;
            drv_rst_q <= 1'b1;
            drv_en_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            drv_rst_q <= drv_rst_d;
            drv_en_q  <= drv_en_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:
                if (commit_req_i)  state_d = S_CHECK;
                else if (enable_i) state_d = S_RUN;
            S_RUN:
                if (commit_req_i)   state_d = S_CHECK;
                else if (!enable_i) state_d = S_IDLE;
            S_CHECK:
                if (|err_v || same_cfg)              state_d = origin_run_q ? S_RUN : S_IDLE;
                else if (bright_only && origin_run_q) state_d = S_WAITFRAME;
                else                                  state_d = S_HALT;
            S_WAITFRAME:
                if (!enable_i)     state_d = S_IDLE;
                else if (buf_edge) state_d = S_RUN;
            S_HALT:    state_d = S_RST;
            S_RST:     if (rst_cnt_q == '0) state_d = S_RELEASE;
            S_RELEASE: state_d = enable_i ? S_RUN : S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so reset can hold drv_rst high in IDLE.
    always_comb begin
        drv_rst_d = (state_d == S_RST);
        drv_en_d  = (state_d == S_RUN) || (state_d == S_WAITFRAME) ||
                    ((state_d == S_CHECK) && (state_q == S_RUN));
        busy_d    = (state_d == S_CHECK) || (state_d == S_WAITFRAME) || (state_d == S_HALT) ||
                    (state_d == S_RST)   || (state_d == S_RELEASE);
    end

    always_comb begin
        rdata_d = '0;
        case (host_addr_i)
            3'd0:    rdata_d = shadow_q[0];
            3'd1:    rdata_d = shadow_q[1];
            3'd2:    rdata_d = shadow_q[2];
            3'd3:    rdata_d = shadow_q[3];
            3'd4:    rdata_d = shadow_q[4];
            3'd5:    rdata_d = W'({cfg_err_q, busy_q, drv_en_q});
            3'd6:    rdata_d = W'(frame_cnt_q);
            default: rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        buf_q <= drv_buffer_i;
        if (ctrl_rst_i) begin
            for (int i = 0; i < 5; i++) begin
                shadow_q[i]  <= reset_val(i);
                pending_q[i] <= reset_val(i);
                active_q[i]  <= reset_val(i);
            end
            cfg_err_q    <= '0;
            frame_cnt_q  <= '0;
            rst_cnt_q    <= '0;
            rdata_q      <= '0;
            origin_run_q <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            if (host_we_i && (host_addr_i < 3'd5))
                shadow_q[host_addr_i] <= host_wdata_i;
            if (state_d == S_CHECK)
                origin_run_q <= (state_q == S_RUN);
            if (state_q == S_CHECK) begin
                for (int i = 0; i < 5; i++) pending_q[i] <= shadow_q[i];
                cfg_err_q <= err_v;
            end
            if (state_q == S_HALT) begin
                for (int i = 0; i < 5; i++) active_q[i] <= pending_q[i];
                rst_cnt_q <= RCW'(RST_CYCLES - 1);
            end else if ((state_q == S_RST) && (rst_cnt_q != '0)) begin
                rst_cnt_q <= rst_cnt_q - RCW'(1);
            end
            if ((state_q == S_WAITFRAME) && (state_d != S_WAITFRAME))
                active_q[4] <= pending_q[4];
            // HALT always precedes RST, so clearing here clears on RST entry.
            if (state_q == S_HALT)
                frame_cnt_q <= '0;
            else if (buf_edge && drv_en_q && !drv_rst_q)
                frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign host_rdata_o     = rdata_q;
    assign drv_rst_o        = drv_rst_q;
    assign drv_en_o         = drv_en_q;
    assign busy_o           = busy_q;
    assign cfg_err_o        = cfg_err_q;
    assign frame_cnt_o      = frame_cnt_q;
    assign drv_n_rows_o     = active_q[0];
    assign drv_n_cols_o     = active_q[1];
    assign drv_bitdepth_o   = active_q[2];
    assign drv_lsb_blank_o  = active_q[3];
    assign drv_brightness_o = active_q[4];
endmodule

// File: tb/tb_led_cfg_sequencer.sv
// Bench for led_cfg_sequencer: commit-timeline model checked every cycle, plus
// hand-computed expectations at the key points of each scenario.
module tb_led_cfg_sequencer;
    localparam int R = 4;

    logic        clk = 1'b0;
    logic        ctrl_rst, host_we, commit_req, enable, drv_buffer;
    logic [2:0]  host_addr;
    logic [31:0] host_wdata, host_rdata;
    logic        drv_rst, drv_en, busy;
    logic [31:0] drv_n_rows, drv_n_cols, drv_bitdepth, drv_lsb_blank, drv_brightness;
    logic [4:0]  cfg_err;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_cfg_sequencer dut (
        .clk_i(clk), .ctrl_rst_i(ctrl_rst), .host_we_i(host_we), .host_addr_i(host_addr),
        .host_wdata_i(host_wdata), .host_rdata_o(host_rdata), .commit_req_i(commit_req),
        .enable_i(enable), .drv_buffer_i(drv_buffer), .drv_rst_o(drv_rst), .drv_en_o(drv_en),
        .drv_n_rows_o(drv_n_rows), .drv_n_cols_o(drv_n_cols), .drv_bitdepth_o(drv_bitdepth),
        .drv_lsb_blank_o(drv_lsb_blank), .drv_brightness_o(drv_brightness), .busy_o(busy),
        .cfg_err_o(cfg_err), .frame_cnt_o(frame_cnt)
    );

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: a commit is tracked by its age in cycles since acceptance (1 = check cycle).
    logic [31:0] m_shadow [5];
    logic [31:0] m_active [5];
    logic [31:0] m_pend   [5];
    logic [31:0] m_rdata, nxt_rdata;
    logic [15:0] m_frame;
    logic [4:0]  m_err, e;
    logic        m_rst, m_en, m_busy, m_prev_buf, m_valid = 1'b0;
    logic        m_run, m_wait, m_origin, edge_seen, same, bonly;
    int          m_age;

    function automatic logic [31:0] dflt(input int i);
        case (i)
            0: return 32'd64;
            1: return 32'd256;
            2: return 32'd8;
            3: return 32'd200;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (ctrl_rst) begin
            for (int i = 0; i < 5; i++) begin
                m_shadow[i] = dflt(i);
                m_active[i] = dflt(i);
            end
            m_rdata = 0; m_frame = 0; m_err = 0;
            m_rst = 1; m_en = 0; m_busy = 0;
            m_run = 0; m_wait = 0; m_age = 0; m_origin = 0;
            m_prev_buf = drv_buffer;
            m_valid = 1;
        end else begin
            case (host_addr)
                3'd0, 3'd1, 3'd2, 3'd3, 3'd4: nxt_rdata = m_shadow[host_addr];
                3'd5: nxt_rdata = {25'd0, m_err, m_busy, m_en};
                3'd6: nxt_rdata = {16'd0, m_frame};
                default: nxt_rdata = 0;
            endcase
            edge_seen = (drv_buffer !== m_prev_buf);
            if (m_en && !m_rst && edge_seen) m_frame = m_frame + 16'd1;
            if (m_wait) begin
                if (!enable || edge_seen) begin
                    m_active[4] = m_pend[4];
                    m_wait = 0;
                    m_run = enable;
                end
            end else if (m_age == 0) begin
                if (commit_req) begin
                    m_origin = m_run;
                    m_age = 1;
                end else begin
                    m_run = enable;
                end
            end else if (m_age == 1) begin
                for (int i = 0; i < 5; i++) m_pend[i] = m_shadow[i];
                e[0] = (m_pend[0] == 0) || (m_pend[0] > 64);
                e[1] = (m_pend[1] == 0) || (m_pend[1] > 256);
                e[2] = (m_pend[2] == 0) || (m_pend[2] > 8);
                e[3] = (m_pend[3] == 0) || (m_pend[3] > 200);
                e[4] = (m_pend[4] >= m_pend[3]);
                bonly = 1;
                for (int i = 0; i < 4; i++) if (m_pend[i] != m_active[i]) bonly = 0;
                same = bonly && (m_pend[4] == m_active[4]);
                m_err = e;
                if (e != 0 || same) begin
                    m_age = 0;
                    m_run = m_origin;
                end else if (bonly && m_origin) begin
                    m_age = 0;
                    m_wait = 1;
                end else begin
                    m_age = 2;
                end
            end else if (m_age == 3 + R) begin
                m_age = 0;
                m_run = enable;
            end else begin
                m_age++;
                if (m_age == 3) begin
                    for (int i = 0; i < 5; i++) m_active[i] = m_pend[i];
                    m_frame = 0;
                end
            end
            if (host_we && host_addr < 3'd5) m_shadow[host_addr] = host_wdata;
            m_rst  = (m_age >= 3) && (m_age <= 2 + R);
            m_en   = m_wait || (m_age == 0 && m_run) || (m_age == 1 && m_origin);
            m_busy = m_wait || (m_age != 0);
            m_rdata = nxt_rdata;
            m_prev_buf = drv_buffer;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            cmp("drv_rst", {31'd0, drv_rst}, {31'd0, m_rst});
            cmp("drv_en", {31'd0, drv_en}, {31'd0, m_en});
            cmp("busy", {31'd0, busy}, {31'd0, m_busy});
            cmp("cfg_err", {27'd0, cfg_err}, {27'd0, m_err});
            cmp("frame_cnt", {16'd0, frame_cnt}, {16'd0, m_frame});
            cmp("host_rdata", host_rdata, m_rdata);
            cmp("drv_n_rows", drv_n_rows, m_active[0]);
            cmp("drv_n_cols", drv_n_cols, m_active[1]);
            cmp("drv_bitdepth", drv_bitdepth, m_active[2]);
            cmp("drv_lsb_blank", drv_lsb_blank, m_active[3]);
            cmp("drv_brightness", drv_brightness, m_active[4]);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        host_we = 1; host_addr = a; host_wdata = d;
        step();
        host_we = 0;
    endtask

    initial begin
        ctrl_rst = 1; host_we = 0; host_addr = 0; host_wdata = 0;
        commit_req = 0; enable = 0; drv_buffer = 0;
        step(3);
        cmp("pin_rst_drv_rst", {31'd0, drv_rst}, 32'd1);
        cmp("pin_rst_busy", {31'd0, busy}, 32'd0);
        ctrl_rst = 0;
        step();
        cmp("pin_idle_drv_rst", {31'd0, drv_rst}, 32'd0);

        enable = 1;
        step();
        cmp("pin_en_after_enable", {31'd0, drv_en}, 32'd1);
        cmp("pin_rows_dflt", drv_n_rows, 32'd64);
        cmp("pin_cols_dflt", drv_n_cols, 32'd256);
        cmp("pin_bits_dflt", drv_bitdepth, 32'd8);
        cmp("pin_blank_dflt", drv_lsb_blank, 32'd200);
        cmp("pin_bright_dflt", drv_brightness, 32'd0);
        host_addr = 3'd5;
        step();
        cmp("pin_status_run", host_rdata, 32'h01);
        drv_buffer = 1; step();
        drv_buffer = 0; step();
        cmp("pin_frame_two", {16'd0, frame_cnt}, 32'd2);

        // full commit from RUN
        wr(3'd1, 32'd128);
        commit_req = 1; step();
        commit_req = 0;
        cmp("pin_full_t1_en", {31'd0, drv_en}, 32'd1);
        step();
        cmp("pin_full_t2_en", {31'd0, drv_en}, 32'd0);
        step();
        cmp("pin_full_t3_rst", {31'd0, drv_rst}, 32'd1);
        cmp("pin_full_t3_cols", drv_n_cols, 32'd128);
        cmp("pin_full_t3_frame", {16'd0, frame_cnt}, 32'd0);
        step(4);
        cmp("pin_full_t7_rst", {31'd0, drv_rst}, 32'd0);
        cmp("pin_full_t7_busy", {31'd0, busy}, 32'd1);
        step();
        cmp("pin_full_t8_en", {31'd0, drv_en}, 32'd1);
        cmp("pin_full_t8_busy", {31'd0, busy}, 32'd0);

        // brightness-only change waits for a frame edge
        wr(3'd4, 32'd50);
        commit_req = 1; step();
        commit_req = 0;
        step(20);
        cmp("pin_wf_bright_old", drv_brightness, 32'd0);
        cmp("pin_wf_busy", {31'd0, busy}, 32'd1);
        drv_buffer = 1; step();
        cmp("pin_wf_bright_new", drv_brightness, 32'd50);
        cmp("pin_wf_busy_done", {31'd0, busy}, 32'd0);

        // invalid commit
        wr(3'd2, 32'd9);
        wr(3'd4, 32'd250);
        commit_req = 1; step();
        commit_req = 0;
        cmp("pin_bad_busy", {31'd0, busy}, 32'd1);
        step();
        cmp("pin_bad_err", {27'd0, cfg_err}, 32'b10100);
        cmp("pin_bad_bits", drv_bitdepth, 32'd8);
        cmp("pin_bad_bright", drv_brightness, 32'd50);
        cmp("pin_bad_en", {31'd0, drv_en}, 32'd1);
        cmp("pin_bad_busy_done", {31'd0, busy}, 32'd0);
        wr(3'd2, 32'd8);
        wr(3'd4, 32'd50);

        // commit while busy is dropped; write during RST reaches shadow only
        wr(3'd0, 32'd32);
        commit_req = 1; step();
        commit_req = 0; step(2);
        wr(3'd0, 32'd16);
        commit_req = 1; step();
        commit_req = 0; step(3);
        cmp("pin_busy_rows", drv_n_rows, 32'd32);
        cmp("pin_busy_en", {31'd0, drv_en}, 32'd1);
        cmp("pin_busy_err_clr", {27'd0, cfg_err}, 32'd0);
        host_addr = 3'd0;
        step();
        cmp("pin_shadow_rows", host_rdata, 32'd16);
        step(5);
        cmp("pin_no_second_commit", {31'd0, busy}, 32'd0);

        // reset in the middle of RST
        commit_req = 1; step();
        commit_req = 0; step(3);
        ctrl_rst = 1; step();
        cmp("pin_midrst_drv_rst", {31'd0, drv_rst}, 32'd1);
        cmp("pin_midrst_en", {31'd0, drv_en}, 32'd0);
        cmp("pin_midrst_busy", {31'd0, busy}, 32'd0);
        cmp("pin_midrst_rows", drv_n_rows, 32'd64);
        ctrl_rst = 0; step(2);
        cmp("pin_reenable_en", {31'd0, drv_en}, 32'd1);
        repeat (3) begin
            drv_buffer = ~drv_buffer;
            step();
        end
        cmp("pin_frame_three", {16'd0, frame_cnt}, 32'd3);

        // full commit from IDLE, with the write on the commit edge
        enable = 0; step();
        host_we = 1; host_addr = 3'd3; host_wdata = 32'd100; commit_req = 1;
        step();
        host_we = 0; commit_req = 0;
        step(9);
        cmp("pin_idle_commit_blank", drv_lsb_blank, 32'd100);
        cmp("pin_idle_commit_en", {31'd0, drv_en}, 32'd0);
        cmp("pin_idle_commit_busy", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
